bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of BUSY cycles without s_ready before an abort (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_valid/m0_instr (in, 1), m0_addr/m0_wdata (in, 32), m0_wstrb (in, 4), m0_rdata (out, 32), m0_ready (out, 1): master 0 (CPU) request/response.
REQ-005 SHALL have ports m1_valid/m1_instr/m1_addr/m1_wdata/m1_wstrb/m1_rdata/m1_ready with the same widths and directions: master 1 (loader/DMA).
REQ-006 SHALL have ports s_valid/s_instr (out, 1), s_addr/s_wdata (out, 32), s_wstrb (out, 4), s_rdata (in, 32), s_ready (in, 1): single slave (on-chip memory).
REQ-007 SHALL have port grant  output  1  index of the master currently owning the slave.
REQ-008 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY0, BUSY1.
REQ-010 SHALL, in IDLE with exactly one mN_valid high, move to BUSYN on the next edge.
REQ-011 SHALL, in IDLE with both valid, grant the master selected by a round-robin pointer; the pointer SHALL give priority to the master not served last.
REQ-012 SHALL, in BUSYN, drive s_valid=1 and s_instr/s_addr/s_wdata/s_wstrb combinationally from master N; in IDLE all s_* outputs SHALL be 0.
REQ-013 SHALL drive both mN_rdata from s_rdata; mN_ready = s_ready AND state==BUSYN; the non-granted master's ready SHALL stay 0.
REQ-014 SHALL return to IDLE on the edge where s_ready=1, updating the round-robin pointer to the served master.
REQ-015 SHALL therefore deassert s_valid the cycle after s_ready, so a slave that accepts on valid && !ready never sees a duplicate request.
REQ-016 SHALL impose latency: request in IDLE at cycle 0 -> s_valid cycle 1 -> m_ready earliest cycle 2 (single-cycle memory); a new grant SHALL not occur before one IDLE cycle.
REQ-017 SHALL require masters to hold request fields stable until their ready; a master dropping valid while BUSY SHALL not abort the transaction.
REQ-018 SHALL drive grant = 1 in BUSY1, 0 otherwise.

Reset
REQ-019 SHALL, on resetn low, asynchronously enter IDLE, set pointer to favour m0, clear timeout counter and err.
REQ-020 SHALL, on reset mid-transaction, deassert s_valid, m0_ready, m1_ready immediately; the in-flight transaction is dropped.
REQ-021 SHALL, after resetn rises, grant nothing until the first rising edge with a valid request.

Configuration
REQ-022 SHALL compile the timeout watchdog only when macro BUS_ARBITER_TIMEOUT_EN is defined.
REQ-023 SHALL, with the macro, count BUSY cycles (reset at each grant); when the count reaches TIMEOUT_CYCLES with s_ready still 0, pulse granted mN_ready for one cycle with mN_rdata = 32'hDEADBEEF, set err, return to IDLE.
REQ-024 SHALL, with the macro, give s_ready priority over timeout when both occur in the same cycle (normal completion, err unchanged).
REQ-025 SHALL, without the macro, wait in BUSY indefinitely and tie err to 0.

Verification
REQ-026 SHALL check: m0 read addr 0x10, slave returns 0x12345678 one cycle after s_valid -> m0_ready pulse at cycle 2, m0_rdata 0x12345678, m1_ready 0.
REQ-027 SHALL check: m0 and m1 valid together after reset -> m0 served first, m1 granted after one IDLE cycle, grant 0 then 1.
REQ-028 SHALL check: m1 write wstrb 4'b0011 wdata 0xAABBCCDD addr 0x20 -> s_wstrb 0011, s_addr 0x20, s_wdata 0xAABBCCDD during BUSY1 only.
REQ-029 SHALL check: resetn low during BUSY0 -> s_valid and m0_ready 0 before next edge, state IDLE.
REQ-030 SHALL check (macro on, TIMEOUT_CYCLES=8): s_ready held 0 -> m0_ready pulses after 8 BUSY cycles with rdata 0xDEADBEEF, err=1 and stays 1; macro off -> no ready, err 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two masters (m0 = CPU, m1 = loader/DMA) share one slave (on-chip memory).
// Both masters requesting at once are resolved round-robin: the master that was not
// served last wins. A grant always passes through IDLE, so the slave sees s_valid drop
// for at least one cycle between transactions.
//
// Optional watchdog: define BUS_ARBITER_TIMEOUT_EN to abort a transaction that has been
// BUSY for TIMEOUT_CYCLES cycles without s_ready. The abort answers the granted master
// with rdata 32'hDEADBEEF and sets the sticky err flag. Without the macro the arbiter
// waits in BUSY indefinitely and err is tied to 0.

module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,

    // master 0 (CPU)
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,

    // master 1 (loader/DMA)
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,

    // slave (on-chip memory)
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,

    output logic        grant,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    // Request fields travelling from a master to the slave as one bundle.
    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

    state_t state;
    state_t state_next;

    // Index of the master served most recently; the other master wins a tie.
    logic   last_served;
    logic   last_served_next;

    // High in the BUSY cycle where the watchdog gives up on the slave.
    logic   timeout_hit;

    req_t   m0_req;
    req_t   m1_req;
    req_t   s_req;

    assign m0_req = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_req = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    // State register and round-robin pointer; reset favours m0 by marking m1 as last served.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples
        // pre-edge values, independent of the order the blocks are evaluated in.
        if (!resetn) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            state       <= state_next;
            last_served <= last_served_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold BUSY until the slave answers or the watchdog fires.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next       = state;
        last_served_next = last_served;
        case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_next = last_served ? BUSY0 : BUSY1;
                end else if (m0_valid) begin
                    state_next = BUSY0;
                end else if (m1_valid) begin
                    state_next = BUSY1;
                end
            end
            BUSY0: begin
                // A master dropping valid here does not end the transaction; only the slave does.
                if (s_ready || timeout_hit) begin
                    state_next       = IDLE;
                    last_served_next = 1'b0;
                end
            end
            BUSY1: begin
                if (s_ready || timeout_hit) begin
                    state_next       = IDLE;
                    last_served_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: route the owning master's request to the slave and the response back to it.
    always_comb begin
        s_req    = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = s_rdata;
        m1_rdata = s_rdata;
        case (state)
            BUSY0: begin
                s_req    = m0_req;
                m0_ready = s_ready || timeout_hit;
                m0_rdata = timeout_hit ? ABORT_RDATA : s_rdata;
            end
            BUSY1: begin
                s_req    = m1_req;
                m1_ready = s_ready || timeout_hit;
                m1_rdata = timeout_hit ? ABORT_RDATA : s_rdata;
            end
            default: begin
            end
        endcase
    end

    // Outputs decode straight from the state register, so an asynchronous reset
    // removes s_valid and both readies without waiting for a clock edge.
    assign s_valid = (state != IDLE);
    assign s_instr = s_req.instr;
    assign s_addr  = s_req.addr;
    assign s_wdata = s_req.wdata;
    assign s_wstrb = s_req.wstrb;
    assign grant   = (state == BUSY1);

`ifdef BUS_ARBITER_TIMEOUT_EN

    localparam int unsigned    CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    // BUSY cycles already spent on the current grant; held at 0 in IDLE so each grant starts fresh.
    logic [CNT_W-1:0] busy_cnt;
    logic             err_q;

    // s_ready is excluded here, which gives a completing slave priority over the watchdog.
    assign timeout_hit = (state != IDLE) && !s_ready && (busy_cnt == CNT_LIMIT);
    assign err         = err_q;

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                busy_cnt <= '0;
            end else if (busy_cnt != CNT_LIMIT) begin
                busy_cnt <= busy_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

`else

    assign timeout_hit = 1'b0;
    assign err         = 1'b0;

    // The limit only matters to the watchdog build; keep it referenced here.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);

`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed stimulus, a transaction-level model of who owns
// the slave, and a per-cycle compare of every DUT output against that model.
// Build with BUS_ARBITER_TIMEOUT_EN defined to exercise the watchdog path.

module tb_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        m0_valid = 1'b0, m0_instr = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [3:0]  m0_wstrb = '0;
    logic [31:0] m0_rdata;
    logic        m0_ready;

    logic        m1_valid = 1'b0, m1_instr = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m1_wstrb = '0;
    logic [31:0] m1_rdata;
    logic        m1_ready;

    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata = '0;
    logic        s_ready = 1'b0;

    logic        grant, err;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave: answers after slave_delay cycles of s_valid ----------------
    int slave_delay = 1;
    int seen = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'h5A5A_0000);
    endfunction

    always @(posedge clk) begin
        if (s_valid && !s_ready) begin
            seen    <= seen + 1;
            s_ready <= (seen + 1 >= slave_delay);
            s_rdata <= mem_data(s_addr);
        end else begin
            seen    <= 0;
            s_ready <= 1'b0;
            s_rdata <= '0;
        end
    end

    // ---------------- model: owner of the slave, -1 when nobody ----------------
    int m_owner = -1;
    int m_last  = 1;
    int m_cnt   = 0;
    bit m_err   = 1'b0;

    function automatic bit model_abort();
`ifdef BUS_ARBITER_TIMEOUT_EN
        return (m_owner >= 0) && !s_ready && (m_cnt == TO);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_owner <= -1;
            m_last  <= 1;
            m_cnt   <= 0;
            m_err   <= 1'b0;
        end else if (m_owner < 0) begin
            m_cnt <= 0;
            if (m0_valid && m1_valid) m_owner <= 1 - m_last;
            else if (m0_valid)        m_owner <= 0;
            else if (m1_valid)        m_owner <= 1;
        end else if (s_ready) begin
            m_last  <= m_owner;
            m_owner <= -1;
        end else if (model_abort()) begin
            m_err   <= 1'b1;
            m_last  <= m_owner;
            m_owner <= -1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic compare_cycle();
        bit          hit;
        logic [68:0] e_req;
        logic [68:0] d_req;
        hit   = model_abort();
        e_req = (m_owner == 0) ? {m0_instr, m0_addr, m0_wdata, m0_wstrb} :
                (m_owner == 1) ? {m1_instr, m1_addr, m1_wdata, m1_wstrb} : '0;
        d_req = {s_instr, s_addr, s_wdata, s_wstrb};
        check("s_valid",  32'(s_valid),   32'(m_owner >= 0));
        check("s_instr",  32'(d_req[68]), 32'(e_req[68]));
        check("s_addr",   d_req[67:36],   e_req[67:36]);
        check("s_wdata",  d_req[35:4],    e_req[35:4]);
        check("s_wstrb",  32'(d_req[3:0]), 32'(e_req[3:0]));
        check("m0_ready", 32'(m0_ready),  32'(m_owner == 0 && (s_ready || hit)));
        check("m1_ready", 32'(m1_ready),  32'(m_owner == 1 && (s_ready || hit)));
        check("m0_rdata", m0_rdata, (m_owner == 0 && hit) ? 32'hDEAD_BEEF : s_rdata);
        check("m1_rdata", m1_rdata, (m_owner == 1 && hit) ? 32'hDEAD_BEEF : s_rdata);
        check("grant",    32'(grant),     32'(m_owner == 1));
        check("err",      32'(err),       32'(m_err));
    endtask

    always @(negedge clk) begin
        if (cmp_en) compare_cycle();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic wait_ready(input bit who, input int bound, output int cycles);
        cycles = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            cycles++;
            if ((who ? m1_ready : m0_ready) === 1'b1) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_ready_m%0d: got no ready in %0d cycles, expected a ready pulse", who, bound);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: got no end of test, expected $finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        bit seen_rdy;

        // reset held from time 0
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("lit_rst_s_valid", 32'(s_valid), 32'd0);
        check("lit_rst_grant",   32'(grant),   32'd0);
        check("lit_rst_err",     32'(err),     32'd0);
        check("lit_rst_m0_ready", 32'(m0_ready), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // m0 read at 0x10 with a single-cycle slave
        m0_valid = 1'b1; m0_instr = 1'b0; m0_addr = 32'h10; m0_wdata = '0; m0_wstrb = 4'b0000;
        check("lit_a_c0_s_valid", 32'(s_valid), 32'd0);
        tick();
        check("lit_a_c1_s_valid", 32'(s_valid), 32'd1);
        check("lit_a_c1_s_addr",  s_addr, 32'h10);
        check("lit_a_c1_grant",   32'(grant), 32'd0);
        check("lit_a_c1_m0_ready", 32'(m0_ready), 32'd0);
        tick();
        check("lit_a_c2_m0_ready", 32'(m0_ready), 32'd1);
        check("lit_a_c2_m0_rdata", m0_rdata, 32'h1234_5678);
        check("lit_a_c2_m1_ready", 32'(m1_ready), 32'd0);
        m0_valid = 1'b0;
        tick();
        check("lit_a_c3_s_valid", 32'(s_valid), 32'd0);

        // both masters after reset: m0 first, one IDLE cycle, then m1
        do_reset();
        m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h40;
        m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h44; m1_wdata = 32'h0102_0304;
        tick();
        check("lit_b_c1_grant",   32'(grant), 32'd0);
        check("lit_b_c1_s_addr",  s_addr, 32'h40);
        check("lit_b_c1_s_instr", 32'(s_instr), 32'd1);
        tick();
        check("lit_b_c2_m0_ready", 32'(m0_ready), 32'd1);
        check("lit_b_c2_m1_ready", 32'(m1_ready), 32'd0);
        m0_valid = 1'b0;
        tick();
        check("lit_b_c3_s_valid", 32'(s_valid), 32'd0);
        tick();
        check("lit_b_c4_grant",  32'(grant), 32'd1);
        check("lit_b_c4_s_addr", s_addr, 32'h44);
        tick();
        check("lit_b_c5_m1_ready", 32'(m1_ready), 32'd1);

        // tie again with m1 served last: m0 must win
        m0_valid = 1'b1; m0_addr = 32'h48; m1_addr = 32'h4C;
        tick();
        check("lit_c_idle_s_valid", 32'(s_valid), 32'd0);
        tick();
        check("lit_c_grant",  32'(grant), 32'd0);
        check("lit_c_s_addr", s_addr, 32'h48);
        wait_ready(1'b0, 10, n);
        m0_valid = 1'b0;
        wait_ready(1'b1, 10, n);
        m1_valid = 1'b0;
        tick();

        // m1 write: request fields reach the slave only during BUSY1
        m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h20; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
        check("lit_d_c0_s_wstrb", 32'(s_wstrb), 32'd0);
        check("lit_d_c0_s_wdata", s_wdata, 32'd0);
        tick();
        check("lit_d_c1_s_wstrb", 32'(s_wstrb), 32'h3);
        check("lit_d_c1_s_addr",  s_addr, 32'h20);
        check("lit_d_c1_s_wdata", s_wdata, 32'hAABB_CCDD);
        check("lit_d_c1_grant",   32'(grant), 32'd1);
        tick();
        check("lit_d_c2_m1_ready", 32'(m1_ready), 32'd1);
        m1_valid = 1'b0;
        tick();
        check("lit_d_c3_s_wstrb", 32'(s_wstrb), 32'd0);
        check("lit_d_c3_s_addr",  s_addr, 32'd0);
        check("lit_d_c3_s_wdata", s_wdata, 32'd0);

        // m0 drops valid while BUSY: transaction still completes
        slave_delay = 4;
        m0_valid = 1'b1; m0_instr = 1'b0; m0_addr = 32'h30;
        tick();
        m0_valid = 1'b0;
        wait_ready(1'b0, 10, n);
        check("lit_drop_latency", 32'(n), 32'd4);
        slave_delay = 1;
        tick();

        // asynchronous reset in the middle of a BUSY0 response cycle
        m0_valid = 1'b1; m0_addr = 32'h50;
        tick();
        tick();
        check("lit_e_pre_m0_ready", 32'(m0_ready), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("lit_e_rst_s_valid",  32'(s_valid),  32'd0);
        check("lit_e_rst_m0_ready", 32'(m0_ready), 32'd0);
        check("lit_e_rst_grant",    32'(grant),    32'd0);
        m0_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        tick();
        check("lit_e_idle_s_valid", 32'(s_valid), 32'd0);
        m0_valid = 1'b1; m0_addr = 32'h54;
        tick();
        check("lit_e_regrant_s_valid", 32'(s_valid), 32'd1);
        check("lit_e_regrant_s_addr",  s_addr, 32'h54);
        wait_ready(1'b0, 10, n);
        m0_valid = 1'b0;
        tick();

        // slave answers in the same cycle the watchdog would fire: normal completion
        do_reset();
        slave_delay = TO;
        m0_valid = 1'b1; m0_addr = 32'h60;
        wait_ready(1'b0, 20, n);
        check("lit_f_cycles",   32'(n), 32'd9);
        check("lit_f_m0_rdata", m0_rdata, 32'h5A5A_0060);
        m0_valid = 1'b0;
        tick();
        check("lit_f_err", 32'(err), 32'd0);

        // slave never answers
        slave_delay = 1000;
        m0_valid = 1'b1; m0_addr = 32'h70;
`ifdef BUS_ARBITER_TIMEOUT_EN
        wait_ready(1'b0, 20, n);
        check("lit_g_cycles",   32'(n), 32'd9);
        check("lit_g_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("lit_g_m1_ready", 32'(m1_ready), 32'd0);
        check("lit_g_err_pre",  32'(err), 32'd0);
        m0_valid = 1'b0;
        tick();
        check("lit_g_err_set",   32'(err), 32'd1);
        check("lit_g_s_valid",   32'(s_valid), 32'd0);
        slave_delay = 1;
        m1_valid = 1'b1; m1_addr = 32'h90;
        wait_ready(1'b1, 10, n);
        check("lit_g_m1_rdata", m1_rdata, 32'h5A5A_0090);
        m1_valid = 1'b0;
        tick();
        check("lit_g_err_sticky", 32'(err), 32'd1);
`else
        seen_rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m0_ready === 1'b1) seen_rdy = 1'b1;
        end
        check("lit_g_no_ready",  32'(seen_rdy), 32'd0);
        check("lit_g_err",       32'(err), 32'd0);
        check("lit_g_still_busy", 32'(s_valid), 32'd1);
        m0_valid = 1'b0;
        slave_delay = 1;
        do_reset();
        tick();
`endif

        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
